perf_counter_section_master: RTL

// - Avalon-MM master driving the 3-section performance counter slave.
// - Converts hardware start/stop pulses from the KNN accelerator into go/stop writes, so software does not time sections.
// - Issues the global-clear write.
// - On request, reads all counters and emits them on a valid/ready result stream.
// - Sits between the accelerator control FSM and the counter's control slave; shares its clk/reset.

---
 rtl/perf_pkg.sv | 22 ++
 rtl/perf_pending_arbiter.sv | 88 ++++++++
 rtl/perf_counter_section_master.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter section master: slave address map,
// FSM states, command opcodes and result word codes.
package perf_pkg;

  localparam int PERF_OFF_STOP   = 0;
  localparam int PERF_OFF_GO     = 1;
  localparam int PERF_OFF_EVT    = 2;
  localparam int PERF_SEC_STRIDE = 4;

  localparam logic [1:0] RES_TIME_LO = 2'd0;
  localparam logic [1:0] RES_TIME_HI = 2'd1;
  localparam logic [1:0] RES_EVT     = 2'd2;

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, OUT} state_e;
  typedef enum logic [1:0] {OP_CLR, OP_STOP, OP_GO, OP_DUMP} cmd_op_e;

  // Word address of a register within a section.
  function automatic logic [3:0] perf_addr(input int unsigned sec, input int unsigned off);
    return 4'(sec * PERF_SEC_STRIDE + off);
  endfunction

endpackage

// File: rtl/perf_pending_arbiter.sv
// Collects start/stop/clear/dump request pulses into sticky pending bits and
// presents the single highest-priority command to the control FSM.
module perf_pending_arbiter
  import perf_pkg::*;
#(
  parameter int NUM_SEC = 3,
  parameter int SEC_W   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SEC-1:0] sec_start,
  input  logic [NUM_SEC-1:0] sec_stop,
  input  logic               clear_req,
  input  logic               dump_req,
  input  logic               accept,
  output logic               cmd_valid,
  output cmd_op_e            cmd_op,
  output logic [SEC_W-1:0]   cmd_sec,
  output logic               pend_any,
  output logic               overflow
);

  logic [NUM_SEC-1:0] pend_start_q, pend_start_d, pend_stop_q, pend_stop_d;
  logic [NUM_SEC-1:0] start_hit, stop_hit, start_ovf, stop_ovf;
  logic               pend_clr_q, pend_clr_d, pend_dump_q, pend_dump_d;
  logic               clr_hit, dump_hit, overflow_q, overflow_d;

  assign clr_hit  = accept && (cmd_op == OP_CLR);
  assign dump_hit = accept && (cmd_op == OP_DUMP);

  // A bit being retired this cycle can take a new pulse without counting as overflow.
  generate
    for (genvar gi = 0; gi < NUM_SEC; gi++) begin : g_sec
      assign start_hit[gi]    = accept && (cmd_op == OP_GO)   && (cmd_sec == SEC_W'(gi));
      assign stop_hit[gi]     = accept && (cmd_op == OP_STOP) && (cmd_sec == SEC_W'(gi));
      assign start_ovf[gi]    = sec_start[gi] & pend_start_q[gi] & ~start_hit[gi];
      assign stop_ovf[gi]     = sec_stop[gi]  & pend_stop_q[gi]  & ~stop_hit[gi];
      assign pend_start_d[gi] = (pend_start_q[gi] & ~start_hit[gi]) | sec_start[gi];
      assign pend_stop_d[gi]  = (pend_stop_q[gi]  & ~stop_hit[gi])  | sec_stop[gi];
    end
  endgenerate

  assign pend_clr_d  = (pend_clr_q  & ~clr_hit)  | clear_req;
  assign pend_dump_d = (pend_dump_q & ~dump_hit) | dump_req;
  assign overflow_d  = overflow_q | (|start_ovf) | (|stop_ovf)
                     | (clear_req & pend_clr_q & ~clr_hit)
                     | (dump_req & pend_dump_q & ~dump_hit);

  always_comb begin
    cmd_valid = 1'b0;
    cmd_op    = OP_DUMP;
    cmd_sec   = '0;
    if (pend_clr_q) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_CLR;
    end else if (|pend_stop_q) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_STOP;
      for (int i = NUM_SEC - 1; i >= 0; i--) if (pend_stop_q[i]) cmd_sec = SEC_W'(i);
    end else if (|pend_start_q) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_GO;
      for (int i = NUM_SEC - 1; i >= 0; i--) if (pend_start_q[i]) cmd_sec = SEC_W'(i);
    end else if (pend_dump_q) begin
      cmd_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_start_q <= '0;
      pend_stop_q  <= '0;
      pend_clr_q   <= 1'b0;
      pend_dump_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      pend_clr_q   <= pend_clr_d;
      pend_dump_q  <= pend_dump_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pend_any = pend_clr_q | pend_dump_q | (|pend_start_q) | (|pend_stop_q);
  assign overflow = overflow_q;

endmodule

// File: rtl/perf_counter_section_master.sv
// Avalon-MM master for the sectioned performance counter: turns accelerator pulses into
// go/stop/clear writes and streams a full counter dump out on a valid/ready interface.
module perf_counter_section_master
  import perf_pkg::*;
#(
  parameter int NUM_SEC = 3,
  parameter int SEC_W   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SEC-1:0] sec_start,
  input  logic [NUM_SEC-1:0] sec_stop,
  input  logic               clear_req,
  input  logic               dump_req,
  output logic               busy,
  output logic               overflow,
  output logic [3:0]         avm_address,
  output logic               avm_write,
  output logic               avm_read,
  output logic [31:0]        avm_writedata,
  input  logic               avm_waitrequest,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_readdatavalid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic [SEC_W-1:0]   res_sec,
  output logic [1:0]         res_word,
  output logic               res_last
);

  state_e             state_q, state_d;
  logic [3:0]         addr_q, addr_d;
  logic               wr_q, wr_d, rd_q, rd_d;
  logic [31:0]        wdata_q, wdata_d, rdata_q, rdata_d;
  logic               res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic [SEC_W-1:0]   sec_q, sec_d, nxt_sec;
  logic [1:0]         word_q, word_d, nxt_word;
  logic               is_last, cmd_accept, cmd_valid, pend_any;
  cmd_op_e            cmd_op;
  logic [SEC_W-1:0]   cmd_sec;

  perf_pending_arbiter #(.NUM_SEC(NUM_SEC), .SEC_W(SEC_W)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .sec_start (sec_start),
    .sec_stop  (sec_stop),
    .clear_req (clear_req),
    .dump_req  (dump_req),
    .accept    (cmd_accept),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_sec   (cmd_sec),
    .pend_any  (pend_any),
    .overflow  (overflow)
  );

  assign is_last = (sec_q == SEC_W'(NUM_SEC - 1)) && (word_q == RES_EVT);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    sec_d       = sec_q;
    word_d      = word_q;
    cmd_accept  = 1'b0;
    nxt_word    = word_q + 2'd1;
    nxt_sec     = sec_q;
    if (word_q == RES_EVT) begin
      nxt_word = RES_TIME_LO;
      nxt_sec  = sec_q + 1'b1;
    end
    case (state_q)
      IDLE: if (cmd_valid) begin
        cmd_accept = 1'b1;
        wdata_d    = 32'd0;
        case (cmd_op)
          OP_CLR:  begin addr_d = 4'd0; wdata_d = 32'd1; wr_d = 1'b1; state_d = WR; end
          OP_STOP: begin addr_d = perf_addr(32'(cmd_sec), PERF_OFF_STOP); wr_d = 1'b1; state_d = WR; end
          OP_GO:   begin addr_d = perf_addr(32'(cmd_sec), PERF_OFF_GO);   wr_d = 1'b1; state_d = WR; end
          default: begin
            sec_d   = '0;
            word_d  = RES_TIME_LO;
            addr_d  = perf_addr(0, 0);
            rd_d    = 1'b1;
            state_d = RD;
          end
        endcase
      end
      WR: if (!avm_waitrequest) begin wr_d = 1'b0; state_d = IDLE; end
      RD: if (!avm_waitrequest) begin rd_d = 1'b0; state_d = RWAIT; end
      RWAIT: if (avm_readdatavalid) begin
        rdata_d     = avm_readdata;
        res_valid_d = 1'b1;
        res_last_d  = is_last;
        state_d     = OUT;
      end
      OUT: if (res_ready) begin
        res_valid_d = 1'b0;
        res_last_d  = 1'b0;
        if (is_last) begin
          state_d = IDLE;
        end else begin
          sec_d   = nxt_sec;
          word_d  = nxt_word;
          addr_d  = perf_addr(32'(nxt_sec), 32'(nxt_word));
          rd_d    = 1'b1;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      sec_q       <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      sec_q       <= sec_d;
      word_q      <= word_d;
    end
  end

  assign busy          = (state_q != IDLE) || pend_any;
  assign avm_address   = addr_q;
  assign avm_write     = wr_q;
  assign avm_read      = rd_q;
  assign avm_writedata = wdata_q;
  assign res_valid     = res_valid_q;
  assign res_data      = rdata_q;
  assign res_sec       = sec_q;
  assign res_word      = word_q;
  assign res_last      = res_last_q;

endmodule
